// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, sign-bit positions and the signed-magnitude
// operand layout used by the arithmetic slices.
package alu_pkg;

    localparam int MAG_W        = 2;
    localparam int OPND_W       = MAG_W + 1;
    localparam int RES_W        = 2 * MAG_W + 1;

    localparam int OPND_SIGN_IDX = OPND_W - 1;
    localparam int RES_SIGN_IDX  = RES_W - 1;

    // Signed-magnitude operand: sign bit on top, unsigned magnitude below.
    typedef struct packed {
        logic             sign;
        logic [MAG_W-1:0] mag;
    } sm_opnd_t;

endpackage

// File: rtl/mag_mult.sv
// Combinational unsigned MAG_W x MAG_W array multiplier: one AND row per bit
// of b, each shifted into place and accumulated through an adder chain.
module mag_mult #(
    parameter int MAG_W = alu_pkg::MAG_W
) (
    input  logic [MAG_W-1:0]   a,
    input  logic [MAG_W-1:0]   b,
    output logic [2*MAG_W-1:0] prod
);

    logic [2*MAG_W-1:0] pp  [MAG_W];
    logic [2*MAG_W-1:0] acc [MAG_W+1];

    assign acc[0] = '0;

    for (genvar i = 0; i < MAG_W; i++) begin : g_row
        assign pp[i]    = {{MAG_W{1'b0}}, a & {MAG_W{b[i]}}} << i;
        assign acc[i+1] = acc[i] + pp[i];
    end

    assign prod = acc[MAG_W];

endmodule

// File: rtl/mul.sv
// Signed-magnitude multiplier slice: sign is the XOR of the operand signs,
// magnitude comes from the unsigned array multiplier, and the product plus
// zero/negative flags are registered together with one cycle of latency.
// A zero magnitude keeps its computed sign, so negative zero is produced.
module mul
    import alu_pkg::*;
#(
    parameter int MAG_W = alu_pkg::MAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [MAG_W:0]   SAB,
    input  logic [MAG_W:0]   SCD,
    output logic [2*MAG_W:0] result,
    output logic             zeroFlag,
    output logic             negativeFlag
);

    logic [2*MAG_W-1:0] mag_p0;
    logic               sign_p0;
    logic               zero_p0;

    mag_mult #(
        .MAG_W (MAG_W)
    ) u_mag_mult (
        .a    (SAB[MAG_W-1:0]),
        .b    (SCD[MAG_W-1:0]),
        .prod (mag_p0)
    );

    // Stage p0: combinational sign and zero detection ahead of the output register
    always_comb begin
        sign_p0 = SAB[MAG_W] ^ SCD[MAG_W];
        zero_p0 = ~|mag_p0;
    end

    // Stage p1: register product and flags together; reset gives positive zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result       <= '0;
            zeroFlag     <= 1'b1;
            negativeFlag <= 1'b0;
        end else begin
            result       <= {sign_p0, mag_p0};
            zeroFlag     <= zero_p0;
            negativeFlag <= sign_p0;
        end
    end

endmodule

// File: tb/tb_mul.sv
// Directed bench for the signed-magnitude multiplier slice.
module tb_mul;
    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [2:0] SAB;
    logic [2:0] SCD;
    logic [4:0] result;
    logic       zeroFlag;
    logic       negativeFlag;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    mul dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .SAB          (SAB),
        .SCD          (SCD),
        .result       (result),
        .zeroFlag     (zeroFlag),
        .negativeFlag (negativeFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {result, zeroFlag, negativeFlag}
    function automatic logic [6:0] observed();
        return {result, zeroFlag, negativeFlag};
    endfunction

    task automatic apply(input logic [2:0] a, input logic [2:0] b);
        @(negedge clk);
        SAB = a;
        SCD = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        SAB   = 3'b111;
        SCD   = 3'b011;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if (observed() !== 7'b00000_1_0)
            $display("FAIL reset_hold got=%b exp=%b", observed(), 7'b00000_1_0);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        SAB   = 3'b011;
        SCD   = 3'b111;
        chk_cnt++;
        if (observed() !== 7'b00000_1_0)
            $display("FAIL reset_release_before_edge got=%b exp=%b", observed(), 7'b00000_1_0);
        else pass_cnt++;
        @(posedge clk);
        #1;
        chk_cnt++;
        if (observed() !== 7'b11001_0_1)
            $display("FAIL first_edge_after_reset got=%b exp=%b", observed(), 7'b11001_0_1);
        else pass_cnt++;
    endtask

    task automatic test_signs();
        apply(3'b011, 3'b111);
        chk_cnt++;
        if (observed() !== 7'b11001_0_1)
            $display("FAIL p3_x_n3 got=%b exp=%b", observed(), 7'b11001_0_1);
        else pass_cnt++;
        apply(3'b110, 3'b111);
        chk_cnt++;
        if (observed() !== 7'b00110_0_0)
            $display("FAIL n2_x_n3 got=%b exp=%b", observed(), 7'b00110_0_0);
        else pass_cnt++;
        apply(3'b101, 3'b010);
        chk_cnt++;
        if (observed() !== 7'b10010_0_1)
            $display("FAIL n1_x_p2 got=%b exp=%b", observed(), 7'b10010_0_1);
        else pass_cnt++;
        apply(3'b010, 3'b011);
        chk_cnt++;
        if (observed() !== 7'b00110_0_0)
            $display("FAIL p2_x_p3 got=%b exp=%b", observed(), 7'b00110_0_0);
        else pass_cnt++;
    endtask

    task automatic test_zero();
        apply(3'b000, 3'b111);
        chk_cnt++;
        if (observed() !== 7'b10000_1_1)
            $display("FAIL p0_x_n3 got=%b exp=%b", observed(), 7'b10000_1_1);
        else pass_cnt++;
        apply(3'b000, 3'b011);
        chk_cnt++;
        if (observed() !== 7'b00000_1_0)
            $display("FAIL p0_x_p3 got=%b exp=%b", observed(), 7'b00000_1_0);
        else pass_cnt++;
        apply(3'b100, 3'b011);
        chk_cnt++;
        if (observed() !== 7'b10000_1_1)
            $display("FAIL n0_x_p3 got=%b exp=%b", observed(), 7'b10000_1_1);
        else pass_cnt++;
        apply(3'b100, 3'b100);
        chk_cnt++;
        if (observed() !== 7'b00000_1_0)
            $display("FAIL n0_x_n0 got=%b exp=%b", observed(), 7'b00000_1_0);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        apply(3'b111, 3'b011);
        chk_cnt++;
        if (observed() !== 7'b11001_0_1)
            $display("FAIL pre_async_reset got=%b exp=%b", observed(), 7'b11001_0_1);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (observed() !== 7'b00000_1_0)
            $display("FAIL async_reset_clear got=%b exp=%b", observed(), 7'b00000_1_0);
        else pass_cnt++;
        @(negedge clk);
        SAB   = 3'b110;
        SCD   = 3'b101;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_cnt++;
        if (observed() !== 7'b00010_0_0)
            $display("FAIL after_async_reset got=%b exp=%b", observed(), 7'b00010_0_0);
        else pass_cnt++;
    endtask

    task automatic test_sweep();
        logic [2:0] vals [7] = '{3'b111, 3'b110, 3'b101, 3'b000, 3'b001, 3'b010, 3'b011};
        logic [6:0] prev_exp;
        logic [6:0] exp;
        sm_opnd_t   a;
        sm_opnd_t   b;
        logic [3:0] m;
        prev_exp = observed();
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 7; j++) begin
                a = sm_opnd_t'(vals[i]);
                b = sm_opnd_t'(vals[j]);
                m = 4'(a.mag) * 4'(b.mag);
                exp = {a.sign ^ b.sign, m, (m == 4'd0), a.sign ^ b.sign};
                @(negedge clk);
                SAB = vals[i];
                SCD = vals[j];
                #1;
                chk_cnt++;
                if (observed() !== prev_exp)
                    $display("FAIL sweep_hold a=%b b=%b got=%b exp=%b", vals[i], vals[j], observed(), prev_exp);
                else pass_cnt++;
                @(posedge clk);
                #1;
                chk_cnt++;
                if (observed() !== exp)
                    $display("FAIL sweep a=%b b=%b got=%b exp=%b", vals[i], vals[j], observed(), exp);
                else pass_cnt++;
                prev_exp = exp;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        SAB   = 3'b000;
        SCD   = 3'b000;
        test_reset();
        test_signs();
        test_zero();
        test_async_reset();
        test_sweep();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mul.md
Name: mul

Overview:
- Signed-magnitude 3-bit × 3-bit multiplier slice of the ALU.
- Produces a 5-bit signed-magnitude product plus zero and negative status flags.
- Outputs are registered on one clock with an asynchronous active-low reset; one-cycle latency.
- Feeds the ALU result/flag mux alongside the other arithmetic slices.

Parameters:
- MAG_W, 2, operand magnitude width; operands are MAG_W+1 bits, result is 2*MAG_W+1 bits. Only the default is verified.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- SAB  input  3  operand A, signed-magnitude: bit2 = sign (1 = negative), bits1:0 = magnitude
- SCD  input  3  operand B, same encoding as SAB
- result  output  5  product, signed-magnitude: bit4 = sign, bits3:0 = magnitude
- zeroFlag  output  1  1 when result[3:0] == 0
- negativeFlag  output  1  equals result[4]

Behaviour:
- Reset: while rst_n = 0, asynchronously force result = 5'b00000, zeroFlag = 1, negativeFlag = 0.
- Reset asserted mid-operation discards the pending product. The first rising edge after release samples the current inputs.
- Latency: SAB/SCD sampled on each rising clk edge. result and flags reflect those inputs immediately after that edge and hold until the next edge.
- No handshake: a new product is computed every cycle.
- Magnitude: result[3:0] = SAB[1:0] * SCD[1:0], unsigned. Maximum is 3*3 = 9, so it never overflows.
- Sign: result[4] = SAB[2] XOR SCD[2], always, including when the magnitude is zero.
  - A zero product with opposite operand signs therefore yields negative zero, 5'b10000.
  - This is required behaviour; the zero result must not be normalised.
- Negative-zero inputs (sign = 1, magnitude = 00) are legal. They are treated as magnitude 0 with their sign bit, e.g. 100 × 011 gives 10000.
- zeroFlag = NOR(result[3:0]); it ignores the sign bit.
- negativeFlag = result[4]; it is 1 for negative zero.
- Flags are registered in the same cycle as result, never combinationally from the inputs.
- No X propagation from the reset state; all outputs are defined from reset onward.

Decomposition:
- Shared package alu_pkg:
  - MAG_W, OPND_W = MAG_W+1, RES_W = 2*MAG_W+1
  - Sign-bit index constants
  - A signed-magnitude operand typedef (sign bit + magnitude field)
- One natural sub-module, mag_mult: a combinational unsigned MAG_W × MAG_W array multiplier (AND partial products plus adders) producing the 2*MAG_W-bit magnitude.
- The top level mul contains:
  - the XOR sign logic
  - the flag logic
  - the output register with async reset

Test Plan:
- Reset: hold rst_n = 0 with arbitrary inputs -> result = 00000, zeroFlag = 1, negativeFlag = 0. Assert rst_n again mid-stream -> outputs clear immediately without waiting for clk.
- SAB = 011 (+3), SCD = 111 (-3), one edge -> result = 11001 (-9), zeroFlag = 0, negativeFlag = 1.
- SAB = 110 (-2), SCD = 111 (-3) -> result = 00110 (+6), zeroFlag = 0, negativeFlag = 0. Also SAB = 101 (-1), SCD = 010 (+2) -> result = 10010, negativeFlag = 1.
- Zero cases:
  - SAB = 000, SCD = 111 -> result = 10000, zeroFlag = 1, negativeFlag = 1.
  - SAB = 000, SCD = 011 -> result = 00000, zeroFlag = 1, negativeFlag = 0.
  - SAB = 100, SCD = 011 -> 10000.
- Exhaustive sweep over all 7 × 7 values of -3..+3 in signed-magnitude, with inputs changed each cycle. Check result against the golden model:
  - sign = XOR of the operand signs
  - magnitude = |a|*|b|
  - flags as specified
  - one-cycle latency (the output lags the inputs by exactly one edge)
